// File: rtl/rc_channel_conditioner.sv
// Multi-channel RC conditioner: snapshots NUM_CH channels on start, then clamps,
// optionally scales and slew-limits each through one shared datapath before publishing all at once.
module rc_channel_conditioner #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned LOW_CUTOFF  = 10,
    parameter int unsigned HIGH_CLAMP  = 250,
    parameter int unsigned KNEE_LO     = 42,
    parameter int unsigned KNEE_HI     = 209,
    parameter int unsigned MID_OFFSET  = 61,
    parameter int unsigned HIGH_OFFSET = 252,
    parameter int unsigned SLEW_LIMIT  = 4
) (
    input  logic                      us_clk,
    input  logic                      resetn,
    input  logic                      start_signal,
    input  logic                      kill,
    input  logic [NUM_CH*WIDTH-1:0]   ch_in,
    input  logic [NUM_CH-1:0]         scale_en,
    input  logic [NUM_CH-1:0]         slew_en,
    output logic [NUM_CH*WIDTH-1:0]   ch_out,
    output logic                      active_signal,
    output logic                      complete_signal
);

    localparam int unsigned SW = WIDTH + 2;
    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef logic signed [SW-1:0] sval_t;

    localparam sval_t LOW_S  = SW'(LOW_CUTOFF);
    localparam sval_t HIGH_S = SW'(HIGH_CLAMP);
    localparam sval_t KLO_S  = SW'(KNEE_LO);
    localparam sval_t KHI_S  = SW'(KNEE_HI);
    localparam sval_t MID_S  = SW'(MID_OFFSET);
    localparam sval_t HOFF_S = SW'(HIGH_OFFSET);
    localparam sval_t SLEW_S = SW'(SLEW_LIMIT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCALE = 3'd1,
        LIMIT = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] snap  [NUM_CH];
    logic [WIDTH-1:0] stage [NUM_CH];
    logic [WIDTH-1:0] prev  [NUM_CH];
    logic [NUM_CH-1:0] scale_q, slew_q;
    logic [CW-1:0]     ch;
    sval_t             s_q;
    logic [WIDTH-1:0]  y_q;

    logic  capture_c, publish_c, active_nx_c;
    sval_t s_c, xs_c, ps_c, t_c;
    logic [WIDTH-1:0] y_c;

    function automatic logic [WIDTH-1:0] clamp_in(input logic [WIDTH-1:0] x);
        if (x < WIDTH'(LOW_CUTOFF)) return '0;
        if (x > WIDTH'(HIGH_CLAMP)) return WIDTH'(HIGH_CLAMP);
        return x;
    endfunction

    // State register
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // Next state and control strobes; kill overrides everything
    always_comb begin
        state_nx  = state;
        capture_c = 1'b0;
        publish_c = 1'b0;
        case (state)
            IDLE: begin
                if (start_signal) begin
                    state_nx  = SCALE;
                    capture_c = 1'b1;
                end
            end
            SCALE:   state_nx = LIMIT;
            LIMIT:   state_nx = WRITE;
            WRITE:   state_nx = (ch == CW'(NUM_CH - 1)) ? DONE : SCALE;
            DONE: begin
                state_nx  = IDLE;
                publish_c = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        if (kill) begin
            state_nx  = IDLE;
            capture_c = 1'b0;
            publish_c = 1'b0;
        end
        active_nx_c = (state_nx == SCALE) || (state_nx == LIMIT) || (state_nx == WRITE);
    end

    // Piecewise-linear curve on the current snapshot channel
    always_comb begin
        xs_c = $signed({2'b00, snap[ch]});
        if (!scale_q[ch])        s_c = xs_c;
        else if (xs_c < KLO_S)   s_c = xs_c + xs_c;
        else if (xs_c > KHI_S)   s_c = xs_c + xs_c - HOFF_S;
        else                     s_c = $signed({3'b000, snap[ch][WIDTH-1:1]}) + MID_S;
    end

    // Idle cut, slew limit against the last published value, output clamp
    always_comb begin
        ps_c = $signed({2'b00, prev[ch]});
        t_c  = '0;
        if (s_q < LOW_S) begin
            y_c = '0;
        end else if (slew_q[ch] && ((s_q - ps_c) > SLEW_S)) begin
            t_c = ps_c + SLEW_S;
            y_c = (t_c > HIGH_S) ? WIDTH'(HIGH_CLAMP) : t_c[WIDTH-1:0];
        end else if (slew_q[ch] && ((ps_c - s_q) > SLEW_S)) begin
            t_c = ps_c - SLEW_S;
            y_c = (t_c < LOW_S) ? '0 : t_c[WIDTH-1:0];
        end else begin
            y_c = (s_q > HIGH_S) ? WIDTH'(HIGH_CLAMP) : s_q[WIDTH-1:0];
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                snap[i]  <= '0;
                stage[i] <= '0;
                prev[i]  <= '0;
            end
            scale_q         <= '0;
            slew_q          <= '0;
            ch              <= '0;
            s_q             <= '0;
            y_q             <= '0;
            ch_out          <= '0;
            active_signal   <= 1'b0;
            complete_signal <= 1'b0;
        end else if (kill) begin
            for (int i = 0; i < NUM_CH; i++) begin
                stage[i] <= '0;
                prev[i]  <= '0;
            end
            ch              <= '0;
            ch_out          <= '0;
            active_signal   <= 1'b0;
            complete_signal <= 1'b0;
        end else begin
            active_signal   <= active_nx_c;
            complete_signal <= publish_c;
            if (capture_c) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    snap[i] <= clamp_in(ch_in[i*WIDTH +: WIDTH]);
                end
                scale_q <= scale_en;
                slew_q  <= slew_en;
                ch      <= '0;
            end
            if (state == SCALE) s_q <= s_c;
            if (state == LIMIT) y_q <= y_c;
            if (state == WRITE) begin
                stage[ch] <= y_q;
                if (ch != CW'(NUM_CH - 1)) ch <= ch + CW'(1);
            end
            if (publish_c) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    ch_out[i*WIDTH +: WIDTH] <= stage[i];
                    prev[i]                  <= stage[i];
                end
            end
        end
    end

endmodule
